// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-AXI bridge: command encodings, FSM states
// and the fixed AXI attribute constants.
package cache_pkg;

  typedef enum logic [2:0] {
    REQ_NONE        = 3'd0,
    REQ_LOAD_BLOCK  = 3'd1,
    REQ_LOAD_WORD   = 3'd2,
    REQ_WRITE_BLOCK = 3'd3,
    REQ_WRITE_WORD  = 3'd4
  } axi_req_e;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_RD_ADDR      = 3'd1,
    S_RD_DATA      = 3'd2,
    S_WR_ADDR_DATA = 3'd3,
    S_WR_RESP      = 3'd4,
    S_DONE         = 3'd5
  } axi_state_e;

  localparam int          BLOCK_WORDS = 4;
  localparam logic [7:0]  BLOCK_LEN   = 8'(BLOCK_WORDS - 1);
  localparam logic [7:0]  SINGLE_LEN  = 8'd0;
  localparam logic [2:0]  SIZE_WORD   = 3'd2;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [3:0]  CACHE_ON    = 4'b1111;
  localparam logic [3:0]  CACHE_OFF   = 4'b0000;
  localparam logic [3:0]  STRB_FULL   = 4'hF;

  function automatic logic is_load(input logic [2:0] cmd);
    return (cmd == REQ_LOAD_BLOCK) || (cmd == REQ_LOAD_WORD);
  endfunction

  function automatic logic is_write(input logic [2:0] cmd);
    return (cmd == REQ_WRITE_BLOCK) || (cmd == REQ_WRITE_WORD);
  endfunction

  function automatic logic is_block(input logic [2:0] cmd);
    return (cmd == REQ_LOAD_BLOCK) || (cmd == REQ_WRITE_BLOCK);
  endfunction

  // Single enabled byte -> byte access, two -> halfword, anything else -> word.
  function automatic logic [2:0] rsize_from_en(input logic [3:0] en);
    logic [2:0] ones;
    ones = 3'(en[0]) + 3'(en[1]) + 3'(en[2]) + 3'(en[3]);
    case (ones)
      3'd1:    return 3'd0;
      3'd2:    return 3'd1;
      default: return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/cache_axi_master.sv
// AXI4 master for a cache: one outstanding block/word read or write at a time,
// accepted only in IDLE and completed with a single-cycle task_finish pulse.
//
// state          | meaning
// S_IDLE         | ready for a command, captured on the accepting edge
// S_RD_ADDR      | arvalid held until AR handshake
// S_RD_DATA      | rready held, beats written into rblock/rword until rlast
// S_WR_ADDR_DATA | AW and W channels run independently until both finish
// S_WR_RESP      | bready held until bvalid
// S_DONE         | one-cycle task_finish pulse
module cache_axi_master
  import cache_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [2:0]   req_to_axi,
  input  logic [31:0]  ad_to_axi,
  input  logic         cached_to_axi,
  input  logic [127:0] wblock_to_axi,
  input  logic [31:0]  wword_to_axi,
  input  logic [3:0]   wword_en_to_axi,
  input  logic [3:0]   rword_en_to_axi,
  output logic         ready_from_axi,
  output logic         task_finish_from_axi,
  output logic [127:0] rblock_from_axi,
  output logic [31:0]  rword_from_axi,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [3:0]   arcache,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  input  logic [1:0]   rresp,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [3:0]   awcache,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  input  logic [1:0]   bresp,
  output logic         bready
);

  axi_state_e   state_q, state_d;
  logic [2:0]   cmd_q;
  logic [31:0]  addr_q;
  logic         cached_q;
  logic [127:0] wblock_q;
  logic [31:0]  wword_q;
  logic [3:0]   wstrb_q;
  logic [3:0]   ren_q;
  logic [1:0]   beat_q;
  logic         aw_done_q;
  logic         w_done_q;
  logic [127:0] rblock_q;
  logic [31:0]  rword_q;

  logic blk;
  logic accept;
  logic ar_fire, r_fire, aw_fire, w_fire, w_last_fire;
  logic aw_complete, w_complete;
  logic [31:0] bus_addr;

  // Error responses complete the transaction like OKAY, so they are not inspected.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};

  assign blk         = is_block(cmd_q);
  assign accept      = (state_q == S_IDLE) && (is_load(req_to_axi) || is_write(req_to_axi));
  assign ar_fire     = arvalid && arready;
  assign r_fire      = rready && rvalid;
  assign aw_fire     = awvalid && awready;
  assign w_fire      = wvalid && wready;
  assign w_last_fire = w_fire && wlast;
  assign aw_complete = aw_done_q || aw_fire;
  assign w_complete  = w_done_q || w_last_fire;

  // Blocks are always fetched/written as a whole aligned line.
  assign bus_addr = blk ? {addr_q[31:4], 4'b0000} : addr_q;

  assign arid    = AXI_ID;
  assign araddr  = bus_addr;
  assign arlen   = blk ? BLOCK_LEN : SINGLE_LEN;
  assign arsize  = blk ? SIZE_WORD : rsize_from_en(ren_q);
  assign arburst = BURST_INCR;
  assign arcache = cached_q ? CACHE_ON : CACHE_OFF;

  assign awid    = AXI_ID;
  assign awaddr  = bus_addr;
  assign awlen   = blk ? BLOCK_LEN : SINGLE_LEN;
  assign awsize  = SIZE_WORD;
  assign awburst = BURST_INCR;
  assign awcache = cached_q ? CACHE_ON : CACHE_OFF;

  assign wdata = blk ? wblock_q[{beat_q, 5'd0} +: 32] : wword_q;
  assign wstrb = blk ? STRB_FULL : wstrb_q;
  assign wlast = blk ? (beat_q == 2'(BLOCK_WORDS - 1)) : 1'b1;

  assign rblock_from_axi = rblock_q;
  assign rword_from_axi  = rword_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = is_load(req_to_axi) ? S_RD_ADDR : S_WR_ADDR_DATA;
        end
      end
      S_RD_ADDR: begin
        if (ar_fire) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (r_fire && rlast) state_d = S_DONE;
      end
      S_WR_ADDR_DATA: begin
        if (aw_complete && w_complete) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bvalid) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_from_axi       = 1'b0;
    task_finish_from_axi = 1'b0;
    arvalid              = 1'b0;
    rready               = 1'b0;
    awvalid              = 1'b0;
    wvalid               = 1'b0;
    bready               = 1'b0;
    case (state_q)
      S_IDLE:         ready_from_axi = 1'b1;
      S_RD_ADDR:      arvalid = 1'b1;
      S_RD_DATA:      rready = 1'b1;
      S_WR_ADDR_DATA: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
      end
      S_WR_RESP:      bready = 1'b1;
      S_DONE:         task_finish_from_axi = 1'b1;
      default:        ;
    endcase
  end

  // The beat counter is shared: read beats in RD_DATA, write beats in WR_ADDR_DATA.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cmd_q     <= REQ_NONE;
      addr_q    <= '0;
      cached_q  <= 1'b0;
      wblock_q  <= '0;
      wword_q   <= '0;
      wstrb_q   <= '0;
      ren_q     <= '0;
      beat_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rblock_q  <= '0;
      rword_q   <= '0;
    end else begin
      if (accept) begin
        cmd_q     <= req_to_axi;
        addr_q    <= ad_to_axi;
        cached_q  <= cached_to_axi;
        wblock_q  <= wblock_to_axi;
        wword_q   <= wword_to_axi;
        wstrb_q   <= wword_en_to_axi;
        ren_q     <= rword_en_to_axi;
        beat_q    <= '0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (r_fire) begin
        rblock_q[{beat_q, 5'd0} +: 32] <= rdata;
        if (cmd_q == REQ_LOAD_WORD) rword_q <= rdata;
        beat_q <= beat_q + 2'd1;
      end
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire) beat_q <= beat_q + 2'd1;
      if (w_last_fire) w_done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_axi_master.sv
// Directed bench for cache_axi_master: a table of transactions driven through a
// scripted AXI slave, plus hand-written reset-abort sequence.
module tb_cache_axi_master;
  import cache_pkg::*;

  logic         clk;
  logic         rstn;
  logic [2:0]   req_to_axi;
  logic [31:0]  ad_to_axi;
  logic         cached_to_axi;
  logic [127:0] wblock_to_axi;
  logic [31:0]  wword_to_axi;
  logic [3:0]   wword_en_to_axi;
  logic [3:0]   rword_en_to_axi;
  logic         ready_from_axi;
  logic         task_finish_from_axi;
  logic [127:0] rblock_from_axi;
  logic [31:0]  rword_from_axi;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arcache;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic         rlast;
  logic         rvalid;
  logic [1:0]   rresp;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [3:0]   awcache;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic [1:0]   bresp;
  logic         bready;

  cache_axi_master #(.AXI_ID(4'h0)) dut (
    .clk(clk), .rstn(rstn),
    .req_to_axi(req_to_axi), .ad_to_axi(ad_to_axi), .cached_to_axi(cached_to_axi),
    .wblock_to_axi(wblock_to_axi), .wword_to_axi(wword_to_axi),
    .wword_en_to_axi(wword_en_to_axi), .rword_en_to_axi(rword_en_to_axi),
    .ready_from_axi(ready_from_axi), .task_finish_from_axi(task_finish_from_axi),
    .rblock_from_axi(rblock_from_axi), .rword_from_axi(rword_from_axi),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rresp(rresp), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   cmd;
    logic [31:0]  ad;
    logic         cached;
    logic [127:0] wblock;
    logic [31:0]  wword;
    logic [3:0]   wen;
    logic [3:0]   ren;
    logic [127:0] rbeats;
    logic [1:0]   resp;
    int           ar_dly;
    int           r_gap;
    int           aw_dly;
    int           w_dly;
    int           b_dly;
    logic [31:0]  exp_addr;
    logic [7:0]   exp_len;
    logic [2:0]   exp_size;
    logic [3:0]   exp_cache;
    logic [127:0] exp_rblock;
    logic [31:0]  exp_rword;
  } vec_t;

  vec_t vecs[7];
  int checks;
  int failures;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input vec_t v);
    chk("ready_idle", ready_from_axi, 1);
    req_to_axi      = v.cmd;
    ad_to_axi       = v.ad;
    cached_to_axi   = v.cached;
    wblock_to_axi   = v.wblock;
    wword_to_axi    = v.wword;
    wword_en_to_axi = v.wen;
    rword_en_to_axi = v.ren;
    step();
    req_to_axi = REQ_NONE;
    chk("ready_busy", ready_from_axi, 0);
  endtask

  task automatic finish_and_idle(input vec_t v);
    chk("finish_pulse", task_finish_from_axi, 1);
    step();
    chk("finish_drop", task_finish_from_axi, 0);
    chk("ready_back", ready_from_axi, 1);
    chk("rblock", rblock_from_axi, v.exp_rblock);
    chk("rword", rword_from_axi, v.exp_rword);
  endtask

  task automatic run_read(input vec_t v);
    int nb;
    nb = (v.exp_len == 8'd3) ? 4 : 1;
    issue(v);
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, v.exp_addr);
    chk("arlen", arlen, v.exp_len);
    chk("arsize", arsize, v.exp_size);
    chk("arcache", arcache, v.exp_cache);
    chk("arburst_arid", {arburst, arid}, {2'b01, 4'h0});
    for (int i = 0; i < v.ar_dly; i++) begin
      // A different command while busy must not disturb the transaction.
      req_to_axi = REQ_WRITE_WORD;
      ad_to_axi  = 32'hFFFF_FFFF;
      step();
      chk("arvalid_hold", arvalid, 1);
    end
    req_to_axi = REQ_NONE;
    chk("araddr_hs", araddr, v.exp_addr);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("arvalid_drop", arvalid, 0);
    chk("rready", rready, 1);
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < v.r_gap; g++) begin
        step();
        chk("rready_gap", rready, 1);
      end
      rvalid = 1'b1;
      rdata  = v.rbeats[b*32 +: 32];
      rlast  = (b == nb - 1);
      rresp  = v.resp;
      step();
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
    finish_and_idle(v);
  endtask

  task automatic run_write(input vec_t v);
    int   nb;
    int   wcnt;
    logic aw_seen;
    nb = (v.exp_len == 8'd3) ? 4 : 1;
    issue(v);
    chk("awvalid", awvalid, 1);
    chk("wvalid", wvalid, 1);
    chk("awaddr", awaddr, v.exp_addr);
    chk("awlen", awlen, v.exp_len);
    chk("awsize", awsize, v.exp_size);
    chk("awcache", awcache, v.exp_cache);
    chk("awburst_awid", {awburst, awid}, {2'b01, 4'h0});
    aw_seen = 1'b0;
    wcnt    = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (aw_seen && wcnt == nb) break;
      awready = (cyc >= v.aw_dly) && !aw_seen;
      wready  = (cyc >= v.w_dly) && (wcnt < nb);
      if (aw_seen) chk("awvalid_drop", awvalid, 0);
      if (wcnt == nb) chk("wvalid_drop", wvalid, 0);
      if (awvalid && awready) begin
        chk("awaddr_hs", awaddr, v.exp_addr);
        aw_seen = 1'b1;
      end
      if (wvalid && wready) begin
        if (nb == 4) begin
          chk("wdata_blk", wdata, v.wblock[wcnt*32 +: 32]);
          chk("wstrb_blk", wstrb, 4'hF);
          chk("wlast_blk", wlast, (wcnt == 3));
        end else begin
          chk("wdata_word", wdata, v.wword);
          chk("wstrb_word", wstrb, v.wen);
          chk("wlast_word", wlast, 1);
        end
        wcnt++;
      end
      step();
    end
    awready = 1'b0;
    wready  = 1'b0;
    chk("wr_channels_done", {aw_seen, (wcnt == nb)}, 2'b11);
    chk("bready", bready, 1);
    chk("wr_valids_low", {awvalid, wvalid}, 2'b00);
    for (int i = 0; i < v.b_dly; i++) begin
      step();
      chk("bready_hold", bready, 1);
    end
    bvalid = 1'b1;
    bresp  = v.resp;
    step();
    bvalid = 1'b0;
    bresp  = 2'b00;
    finish_and_idle(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn = 1'b0;
    req_to_axi = REQ_NONE;
    ad_to_axi = '0;
    cached_to_axi = 1'b0;
    wblock_to_axi = '0;
    wword_to_axi = '0;
    wword_en_to_axi = '0;
    rword_en_to_axi = '0;
    arready = 1'b0;
    rdata = '0;
    rlast = 1'b0;
    rvalid = 1'b0;
    rresp = 2'b00;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    bresp = 2'b00;

    vecs[0] = '{REQ_LOAD_BLOCK, 32'h1C00_0014, 1'b1, 128'h0, 32'h0, 4'h0, 4'h0,
                128'h00000044_00000033_00000022_00000011, 2'b00, 1, 1, 0, 0, 0,
                32'h1C00_0010, 8'd3, 3'd2, 4'hF,
                128'h00000044_00000033_00000022_00000011, 32'h0};
    vecs[1] = '{REQ_LOAD_WORD, 32'hBFAF_8003, 1'b0, 128'h0, 32'h0, 4'h0, 4'b1000,
                128'h00000000_00000000_00000000_DEADBEEF, 2'b10, 0, 0, 0, 0, 0,
                32'hBFAF_8003, 8'd0, 3'd0, 4'h0,
                128'h00000044_00000033_00000022_DEADBEEF, 32'hDEAD_BEEF};
    vecs[2] = '{REQ_LOAD_WORD, 32'h0000_1002, 1'b1, 128'h0, 32'h0, 4'h0, 4'b1100,
                128'h00000000_00000000_00000000_12345678, 2'b00, 2, 2, 0, 0, 0,
                32'h0000_1002, 8'd0, 3'd1, 4'hF,
                128'h00000044_00000033_00000022_12345678, 32'h1234_5678};
    vecs[3] = '{REQ_LOAD_WORD, 32'h2000_0004, 1'b0, 128'h0, 32'h0, 4'h0, 4'b1111,
                128'h00000000_00000000_00000000_CAFEF00D, 2'b00, 0, 0, 0, 0, 0,
                32'h2000_0004, 8'd0, 3'd2, 4'h0,
                128'h00000044_00000033_00000022_CAFEF00D, 32'hCAFE_F00D};
    vecs[4] = '{REQ_WRITE_BLOCK, 32'h8000_003C, 1'b1,
                128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 32'h0, 4'h0, 4'h0,
                128'h0, 2'b00, 0, 0, 0, 3, 1,
                32'h8000_0030, 8'd3, 3'd2, 4'hF,
                128'h00000044_00000033_00000022_CAFEF00D, 32'hCAFE_F00D};
    vecs[5] = '{REQ_WRITE_WORD, 32'h9000_0006, 1'b0, 128'h0, 32'h5555_AAAA, 4'b0011, 4'h0,
                128'h0, 2'b10, 0, 0, 0, 0, 2,
                32'h9000_0006, 8'd0, 3'd2, 4'h0,
                128'h00000044_00000033_00000022_CAFEF00D, 32'hCAFE_F00D};
    vecs[6] = '{REQ_WRITE_BLOCK, 32'h7000_0008, 1'b0,
                128'h44444444_33333333_22222222_11111111, 32'h0, 4'h0, 4'h0,
                128'h0, 2'b11, 0, 0, 4, 0, 0,
                32'h7000_0000, 8'd3, 3'd2, 4'h0,
                128'h00000044_00000033_00000022_CAFEF00D, 32'hCAFE_F00D};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_ready", ready_from_axi, 1);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, task_finish_from_axi}, 6'b0);
    chk("rst_rblock", rblock_from_axi, 128'h0);
    chk("rst_rword", rword_from_axi, 32'h0);
    step();

    for (int i = 0; i < 7; i++) begin
      if (is_load(vecs[i].cmd)) run_read(vecs[i]);
      else run_write(vecs[i]);
      step();
    end

    // Reset while a block read is mid-burst: abort straight back to IDLE.
    req_to_axi = REQ_LOAD_BLOCK;
    ad_to_axi  = 32'h0000_0100;
    cached_to_axi = 1'b1;
    step();
    req_to_axi = REQ_NONE;
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'h0000_0077;
    rlast  = 1'b0;
    step();
    rvalid = 1'b0;
    chk("abort_in_rdata", rready, 1);
    rstn = 1'b0;
    step();
    chk("abort_ready", ready_from_axi, 1);
    chk("abort_arvalid", arvalid, 0);
    chk("abort_rready", rready, 0);
    chk("abort_finish", task_finish_from_axi, 0);
    chk("abort_rblock", rblock_from_axi, 128'h0);
    rstn = 1'b1;
    step();
    chk("abort_idle_hold", {ready_from_axi, arvalid}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
